// File: rtl/if_id_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register and the decode stage that consumes it.
// Holds the bubble encoding, branch-kind bit positions and the IF/ID bundle layout.
package if_id_reg_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // addi x0,x0,0: architecturally a no-op, so a bubble flowing into decode has no side effects.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam int unsigned BR_KIND_W = 6;
  localparam int unsigned BR_BEQ    = 5;
  localparam int unsigned BR_BNE    = 4;
  localparam int unsigned BR_BLT    = 3;
  localparam int unsigned BR_BGE    = 2;
  localparam int unsigned BR_BLTU   = 1;
  localparam int unsigned BR_BGEU   = 0;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  instr;
    logic [XLEN_DEF-1:0]  pc;
    logic [XLEN_DEF-1:0]  pc_add_4;
    logic                 B_type_result;
    logic                 jal;
    logic                 jalr;
    logic                 B_type;
    logic [BR_KIND_W-1:0] br_kind;
    logic                 valid;
  } if_id_bundle_t;

  // Non-branch instructions may carry junk in the kind field; only a real branch keeps it.
  function automatic logic [BR_KIND_W-1:0] mask_br_kind(input logic                 b_type,
                                                        input logic [BR_KIND_W-1:0] br_kind);
    return b_type ? br_kind : '0;
  endfunction

endpackage

// File: rtl/if_id_reg_sat_counter.sv
// Saturating up-counter used for the IF/ID bubble and flush statistics.
// Synchronous clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_max;

  assign w_at_max = (r_cnt == {CNT_W{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch results and applies flush, hold and bubble control.
// Also keeps saturating counts of stall bubbles and flush bubbles.
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(RV_NOP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      instr_if,
  input  logic [XLEN-1:0]      pc_if,
  input  logic [XLEN-1:0]      pc_add_4_if,
  input  logic                 B_type_result_if,
  input  logic                 jal_if,
  input  logic                 jalr_if,
  input  logic                 B_type_if,
  input  logic [BR_KIND_W-1:0] br_kind_if,
  input  logic                 PL_stall_ex,
  input  logic                 PL_stall_if,
  input  logic                 PL_flush,
  output logic [XLEN-1:0]      instr_if_id_o,
  output logic [XLEN-1:0]      pc_if_id_o,
  output logic [XLEN-1:0]      pc_add_4_if_id_o,
  output logic                 B_type_result_if_id_o,
  output logic                 jal_if_id_o,
  output logic                 jalr_if_id_o,
  output logic                 B_type_if_id_o,
  output logic [BR_KIND_W-1:0] br_kind_if_id_o,
  output logic                 valid_if_id_o,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  logic [XLEN-1:0]      r_instr;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_pc_add_4;
  logic                 r_b_type_result;
  logic                 r_jal;
  logic                 r_jalr;
  logic                 r_b_type;
  logic [BR_KIND_W-1:0] r_br_kind;
  logic                 r_valid;

  logic w_hold;
  logic w_stall_bubble;
  logic w_load_bubble;

  // Flush beats a downstream hold so a mispredicted instruction can never sit in ID.
  assign w_hold         = !PL_flush && PL_stall_ex;
  assign w_stall_bubble = !PL_flush && !PL_stall_ex && PL_stall_if;
  assign w_load_bubble  = PL_flush || w_stall_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr         <= NOP_INSTR;
      r_pc            <= '0;
      r_pc_add_4      <= '0;
      r_b_type_result <= 1'b0;
      r_jal           <= 1'b0;
      r_jalr          <= 1'b0;
      r_b_type        <= 1'b0;
      r_br_kind       <= '0;
      r_valid         <= 1'b0;
    end else if (!w_hold) begin
      // PCs load even for bubbles so a trace shows where the bubble came from.
      r_pc       <= pc_if;
      r_pc_add_4 <= pc_add_4_if;
      if (w_load_bubble) begin
        r_instr         <= NOP_INSTR;
        r_b_type_result <= 1'b0;
        r_jal           <= 1'b0;
        r_jalr          <= 1'b0;
        r_b_type        <= 1'b0;
        r_br_kind       <= '0;
        r_valid         <= 1'b0;
      end else begin
        r_instr         <= instr_if;
        r_b_type_result <= B_type_result_if;
        r_jal           <= jal_if;
        r_jalr          <= jalr_if;
        r_b_type        <= B_type_if;
        r_br_kind       <= mask_br_kind(B_type_if, br_kind_if);
        r_valid         <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_stall_bubble),
    .o_cnt (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (PL_flush),
    .o_cnt (flush_cnt)
  );

  assign instr_if_id_o         = r_instr;
  assign pc_if_id_o            = r_pc;
  assign pc_add_4_if_id_o      = r_pc_add_4;
  assign B_type_result_if_id_o = r_b_type_result;
  assign jal_if_id_o           = r_jal;
  assign jalr_if_id_o          = r_jalr;
  assign B_type_if_id_o        = r_b_type;
  assign br_kind_if_id_o       = r_br_kind;
  assign valid_if_id_o         = r_valid;

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the fetch stage and the decode stage.
- Captures the fetched instruction, its PC, PC+4 and the branch bookkeeping that fetch produces: static prediction result, jump/branch type flags, and the one-hot branch kind.
- Applies the pipeline control: stall hold, flush-to-bubble, and bubble insertion when fetch stalls.
- Keeps two saturating event counters (bubbles, flushes) for performance analysis.

Parameters:
- XLEN, 32, width of instruction, PC and PC+4 fields
- CNT_W, 16, width of each saturating event counter
- NOP_INSTR, 32'h0000_0013, encoding loaded on bubble, flush or reset (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_if  in  XLEN  instruction from fetch (already nop when fetch stalls)
- pc_if  in  XLEN  PC of the fetched instruction
- pc_add_4_if  in  XLEN  PC+4 from fetch
- B_type_result_if  in  1  fetch-stage taken/not-taken decision
- jal_if  in  1  instruction is JAL
- jalr_if  in  1  instruction is JALR
- B_type_if  in  1  instruction is a conditional branch
- br_kind_if  in  6  one-hot {beq,bne,blt,bge,bltu,bgeu}
- PL_stall_ex  in  1  downstream stall; hold all contents
- PL_stall_if  in  1  fetch-stage stall; load a bubble
- PL_flush  in  1  mispredict flush; load a bubble
- instr_if_id_o  out  XLEN  registered instruction
- pc_if_id_o  out  XLEN  registered PC
- pc_add_4_if_id_o  out  XLEN  registered PC+4
- B_type_result_if_id_o  out  1  registered prediction result
- jal_if_id_o  out  1  registered JAL flag
- jalr_if_id_o  out  1  registered JALR flag
- B_type_if_id_o  out  1  registered branch flag
- br_kind_if_id_o  out  6  registered branch kind
- valid_if_id_o  out  1  1 = real instruction, 0 = bubble
- bubble_cnt  out  CNT_W  count of cycles that loaded a stall bubble
- flush_cnt  out  CNT_W  count of cycles that loaded a flush bubble

Behaviour:
- Reset (rst=1 at a rising edge) forces:
  - instr = NOP_INSTR
  - pc, pc_add_4 = 0
  - all flags, br_kind, valid = 0
  - both counters = 0
- Reset overrides every other input in the same cycle.
- Per-edge update priority (highest first):
  1. rst: reset values.
  2. PL_flush: load bubble (see below); flush_cnt += 1. Flush wins over PL_stall_ex and PL_stall_if asserted in the same cycle, so a mispredicted path is never held.
  3. PL_stall_ex: hold every field and valid unchanged; counters unchanged.
  4. PL_stall_if: load bubble; bubble_cnt += 1.
  5. Otherwise: load all inputs; valid = 1.
- Bubble contents:
  - instr = NOP_INSTR
  - jal, jalr, B_type, B_type_result, br_kind = 0
  - valid = 0
  - pc and pc_add_4 still load pc_if and pc_add_4_if, for debug traceability.
- Latency: exactly 1 cycle from input to output.
- No combinational path from any input to any output.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Invariants:
  - Exactly one counter increments per cycle at most.
  - br_kind is either all-zero or one-hot. When B_type_if=0 the register stores zeros regardless of br_kind_if, which masks decode garbage.
  - valid_if_id_o=0 implies instr_if_id_o == NOP_INSTR and all flags are 0.
- Stall held across many cycles: contents stay bit-identical. The first cycle after PL_stall_ex drops loads the current inputs.

Decomposition:
- Shared package holds:
  - NOP_INSTR constant
  - br_kind bit indices (BEQ=5 .. BGEU=0)
  - a packed if_id bundle struct {instr, pc, pc_add_4, B_type_result, jal, jalr, B_type, br_kind, valid}, for reuse by the id stage.
- One sub-module, sat_counter (CNT_W width; inc, clr inputs), instantiated twice.
- Everything else is inline sequential logic.

Test Plan:
- Reset → instr_if_id_o=0x00000013, pc_if_id_o=0, valid=0, bubble_cnt=flush_cnt=0.
- Load: pc_if=0x100, instr_if=0x00A00093, no stalls → next cycle pc_if_id_o=0x100, instr=0x00A00093, valid=1, pc_add_4_if_id_o=0x104.
- Hold: load beq at pc 0x200 (B_type=1, br_kind=6'b100000, B_type_result=1), then PL_stall_ex=1 for 3 cycles with changing inputs → outputs stay 0x200/beq/taken all 3 cycles; counters stay 0.
- Flush priority: PL_flush=1 with PL_stall_ex=1 and PL_stall_if=1 → next cycle instr=0x13, valid=0, flags=0; flush_cnt=1, bubble_cnt=0.
- Bubble: PL_stall_if=1 for 5 cycles with pc_if=0x300 → instr=0x13, valid=0, pc_if_id_o=0x300, bubble_cnt=5.
- Saturation: CNT_W=2, 6 consecutive PL_stall_if cycles → bubble_cnt sequence 1,2,3,3,3,3. Then rst=1 → bubble_cnt=0.
